// File: rtl/sing_io_hdx_link.sv
// Half-duplex single-wire UART-style transceiver driving an external IOBUF.
// It listens with the pad released, transmits only when the line is idle, and releases the pad for a guard interval after every frame.
module sing_io_hdx_link #(
    parameter int CLKS_PER_BIT = 868,
    parameter int GUARD_BITS   = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pad_o,
    output logic       pad_i,
    output logic       pad_t,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    GUARD_LAST = 4'(GUARD_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RX_START = 3'd1,
        ST_RX_DATA  = 3'd2,
        ST_RX_STOP  = 3'd3,
        ST_TX       = 3'd4,
        ST_GUARD    = 3'd5
    } state_t;

    state_t                 state_r, state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_line_r;
    logic                   line_s, start_det_s, cnt_zero_s, tx_ready_s;
    logic [CW-1:0]          cnt_r, cnt_s;
    logic [3:0]             idx_r, idx_s;
    logic [7:0]             shift_r, shift_s, tx_byte_r, tx_byte_s;
    logic                   pad_t_r, pad_t_s, pad_i_r, pad_i_s;
    logic [7:0]             rx_data_r, rx_data_s;
    logic                   rx_valid_r, rx_valid_s, frame_err_r, frame_err_s;

    // Frame bit k of a TX byte: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic tx_bit(input logic [7:0] b, input logic [3:0] k);
        logic r;
        case (k)
            4'd0:    r = 1'b0;
            4'd9:    r = 1'b1;
            default: r = b[3'(k - 4'd1)];
        endcase
        return r;
    endfunction

    assign line_s      = sync_r[SYNC_STAGES-1];
    assign start_det_s = ~line_s & prev_line_r;
    assign cnt_zero_s  = (cnt_r == '0);
    assign tx_ready_s  = (state_r == ST_IDLE) && !start_det_s;

    assign tx_ready  = tx_ready_s;
    assign busy      = (state_r != ST_IDLE);
    assign pad_t     = pad_t_r;
    assign pad_i     = pad_i_r;
    assign rx_data   = rx_data_r;
    assign rx_valid  = rx_valid_r;
    assign frame_err = frame_err_r;

    // Pad synchronizer and previous-level flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r      <= '1;
            prev_line_r <= 1'b1;
        end else begin
            sync_r      <= {sync_r[SYNC_STAGES-2:0], pad_o};
            prev_line_r <= line_s;
        end
    end

    // Next-state, counters and registered-output values.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        idx_s       = idx_r;
        shift_s     = shift_r;
        tx_byte_s   = tx_byte_r;
        pad_t_s     = 1'b1;
        pad_i_s     = 1'b1;
        rx_data_s   = rx_data_r;
        rx_valid_s  = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_det_s) begin
                    state_s = ST_RX_START;
                    cnt_s   = HALF_LAST;
                end else if (tx_valid && tx_ready_s) begin
                    state_s   = ST_TX;
                    tx_byte_s = tx_data;
                    cnt_s     = BIT_LAST;
                    idx_s     = 4'd0;
                    pad_t_s   = 1'b0;
                    pad_i_s   = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RX_START: begin
                if (cnt_zero_s) begin
                    if (!line_s) begin
                        state_s = ST_RX_DATA;
                        cnt_s   = BIT_LAST;
                        idx_s   = 4'd0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_RX_DATA: begin
                if (cnt_zero_s) begin
                    shift_s = {line_s, shift_r[7:1]};
                    cnt_s   = BIT_LAST;
                    if (idx_r == 4'd7) begin
                        state_s = ST_RX_STOP;
                        idx_s   = 4'd0;
                    end else begin
                        idx_s = idx_r + 4'd1;
                    end
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_RX_STOP: begin
                if (cnt_zero_s) begin
                    if (line_s) begin
                        rx_data_s  = shift_r;
                        rx_valid_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                    state_s = ST_GUARD;
                    cnt_s   = BIT_LAST;
                    idx_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_TX: begin
                // line_s carries our own echo here, so it is not looked at.
                pad_t_s = 1'b0;
                pad_i_s = pad_i_r;
                if (cnt_zero_s) begin
                    cnt_s = BIT_LAST;
                    if (idx_r == 4'd9) begin
                        state_s = ST_GUARD;
                        idx_s   = 4'd0;
                        pad_t_s = 1'b1;
                        pad_i_s = 1'b1;
                    end else begin
                        idx_s   = idx_r + 4'd1;
                        pad_i_s = tx_bit(tx_byte_r, idx_r + 4'd1);
                    end
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            ST_GUARD: begin
                if (cnt_zero_s) begin
                    cnt_s = BIT_LAST;
                    if (idx_r == GUARD_LAST) begin
                        state_s = ST_IDLE;
                        idx_s   = 4'd0;
                    end else begin
                        idx_s = idx_r + 4'd1;
                    end
                end else begin
                    cnt_s = cnt_r - 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset releases the pad without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            idx_r       <= 4'd0;
            shift_r     <= 8'd0;
            tx_byte_r   <= 8'd0;
            pad_t_r     <= 1'b1;
            pad_i_r     <= 1'b1;
            rx_data_r   <= 8'd0;
            rx_valid_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            idx_r       <= idx_s;
            shift_r     <= shift_s;
            tx_byte_r   <= tx_byte_s;
            pad_t_r     <= pad_t_s;
            pad_i_r     <= pad_i_s;
            rx_data_r   <= rx_data_s;
            rx_valid_r  <= rx_valid_s;
            frame_err_r <= frame_err_s;
        end
    end
endmodule

// File: tb/tb_sing_io_hdx_link.sv
// Self-checking bench for sing_io_hdx_link: directed and random RX/TX frames against a frame-level model.
module tb_sing_io_hdx_link;
    localparam int CPB = 4;

    logic       clk, rst_n, pad_o, pad_i, pad_t, line_drv;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_ready, rx_valid, frame_err, busy;

    int   n_cmp = 0;
    int   n_err = 0;
    int   rxv_cnt = 0;
    int   fe_cnt = 0;
    int   padt_low = 0;
    logic txq[$];
    logic [7:0] last_good = 8'd0;

    // The pad: our own driven level when pad_t=0, otherwise the remote/pull-up level.
    assign pad_o = pad_t ? line_drv : pad_i;

    sing_io_hdx_link #(.CLKS_PER_BIT(CPB), .GUARD_BITS(2), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pad_o(pad_o), .pad_i(pad_i), .pad_t(pad_t),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and record of every driven pad cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) rxv_cnt++;
            if (frame_err) fe_cnt++;
            if (!pad_t) begin
                padt_low++;
                txq.push_back(pad_i);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts busy cycles starting at the current negedge.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
    endtask

    // Drives one frame on the line; optionally raises tx_valid exactly on start_det.
    task automatic run_rx(input logic [7:0] d, input logic stop, input bit raise_tx, input string tag);
        int bv, be, bl, n;
        logic [9:0] frame;
        bv = rxv_cnt; be = fe_cnt; bl = padt_low;
        frame = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            line_drv = frame[k];
            for (int c = 0; c < CPB; c++) begin
                if (raise_tx && k == 0 && c == 2) begin
                    tx_valid = 1'b1;
                    chk({tag, "_ready_at_start"}, tx_ready, 1'b0);
                end
                @(negedge clk);
            end
        end
        line_drv = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_valid || frame_err) break;
        end
        if (stop) last_good = d;
        chk({tag, "_pulse"}, {rx_valid, frame_err}, {stop, ~stop});
        chk({tag, "_data"}, rx_data, last_good);
        count_busy(n);
        chk({tag, "_guard"}, n, 8);
        chk({tag, "_rxv_cnt"}, rxv_cnt - bv, {63'd0, stop});
        chk({tag, "_fe_cnt"}, fe_cnt - be, {63'd0, ~stop});
        chk({tag, "_no_drive"}, padt_low - bl, 0);
        chk({tag, "_ready_end"}, tx_ready, 1'b1);
    endtask

    // Caller has tx_valid=1 with tx_data=d at an IDLE negedge.
    task automatic run_tx(input logic [7:0] d, input string tag);
        int base, bl, n;
        logic [39:0] obs, exp;
        logic [9:0] frame;
        base = txq.size(); bl = padt_low;
        chk({tag, "_ready"}, tx_ready, 1'b1);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = 8'($urandom);
        for (int i = 0; i < 60; i++) begin
            if (pad_t) break;
            @(negedge clk);
        end
        chk({tag, "_released_hi"}, pad_i, 1'b1);
        count_busy(n);
        chk({tag, "_guard"}, n, 8);
        chk({tag, "_drive_len"}, padt_low - bl, 40);
        frame = {1'b1, d, 1'b0};
        for (int k = 0; k < 40; k++) begin
            exp[k] = frame[k / CPB];
            obs[k] = (base + k < txq.size()) ? txq[base + k] : 1'bx;
        end
        chk({tag, "_bits"}, obs, exp);
        chk({tag, "_ready_end"}, tx_ready, 1'b1);
    endtask

    initial begin
        int nb, bv, be;
        logic [7:0] d, d2;
        rst_n = 1'b0; line_drv = 1'b1; tx_valid = 1'b0; tx_data = 8'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            chk("idle_outputs", {pad_t, pad_i, busy, rx_valid, frame_err, tx_ready}, 6'b110001);
            @(negedge clk);
        end
        chk("reset_rx_data", rx_data, 8'h00);

        run_rx(8'hA5, 1'b1, 1'b0, "rx_a5");

        tx_valid = 1'b1; tx_data = 8'h3C;
        run_tx(8'h3C, "tx_3c");

        // One-cycle glitch: mid-start sample sees high, back to IDLE with no guard.
        bv = rxv_cnt; be = fe_cnt; nb = 0;
        line_drv = 1'b0;
        @(negedge clk);
        line_drv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (busy) nb++;
            @(negedge clk);
        end
        chk("glitch_busy_cycles", nb, 2);
        chk("glitch_no_pulse", {rxv_cnt - bv, fe_cnt - be}, 64'd0);
        chk("glitch_ready", tx_ready, 1'b1);

        run_rx(8'h5A, 1'b0, 1'b0, "rx_5a_ferr");

        d = 8'($urandom); d2 = 8'($urandom);
        tx_data = d2;
        run_rx(d, 1'b1, 1'b1, "rx_vs_tx");
        run_tx(d2, "tx_after_rx");

        for (int it = 0; it < 6; it++) begin
            d = 8'($urandom);
            case ($urandom_range(0, 2))
                0: run_rx(d, 1'b1, 1'b0, "rnd_rx");
                1: run_rx(d, 1'b0, 1'b0, "rnd_ferr");
                default: begin
                    tx_valid = 1'b1; tx_data = d;
                    run_tx(d, "rnd_tx");
                end
            endcase
        end

        // Reset in the middle of a transmission.
        tx_valid = 1'b1; tx_data = 8'($urandom);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("midtx_driving", pad_t, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midtx_async_release", {pad_t, pad_i, busy}, 3'b110);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("after_reset_idle", {pad_t, busy, tx_ready}, 3'b101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sing_io_hdx_link.md
Name: sing_io_hdx_link

Overview:
- Half-duplex single-wire serial transceiver that owns one shared bidirectional pad through an external IOBUF. It drives the IOBUF I/T inputs and samples its O output.
- Idles released (hi-Z) and listens for frames. Transmits only when the line is free.
- Frame format: UART-style, 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). A guard turnaround interval follows every frame.
- Pairs with a peer board or a second instance to test bidirectional pad direction switching in hardware.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period. Must be >= 4.
- GUARD_BITS, 2, bit periods with the line released after any frame, before a new RX/TX may start.
- SYNC_STAGES, 2, flops in the pad_o synchronizer. Must be >= 2.

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- pad_o  input  1  from IOBUF.O, pad level (external pull-up keeps idle high)
- pad_i  output  1  to IOBUF.I, level driven when pad_t=0
- pad_t  output  1  to IOBUF.T, 1 = released (hi-Z), 0 = driving
- tx_data  input  8  byte to send, sampled on handshake
- tx_valid  input  1  request to send
- tx_ready  output  1  accept; transfer occurs when tx_valid & tx_ready
- rx_data  output  8  last correctly received byte
- rx_valid  output  1  one-cycle pulse, rx_data updated
- frame_err  output  1  one-cycle pulse, stop bit sampled low
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - pad_t=1, pad_i=1, rx_data=0, rx_valid=0, frame_err=0, busy=0.
  - State=IDLE, all synchronizer flops=1.
  - Reset asserted mid-TX releases the pad immediately, without waiting for a clock.
- Synchronizer: pad_o passes through SYNC_STAGES flops, giving line_s. Falling-edge detect (start_det) is line_s=0 with the previous line_s=1.
- tx_ready is combinational: (state==IDLE) & !start_det.
- States and transitions:
  - IDLE: pad_t=1. If start_det, go to RX_START and load the bit counter with CLKS_PER_BIT/2-1. Else if tx_valid & tx_ready, latch tx_data and go to TX. RX wins over TX in the same cycle.
  - RX_START: at counter expiry, sample line_s. If 0, go to RX_DATA (bit index 0, counter reloaded with CLKS_PER_BIT-1). If 1 it was a glitch: return to IDLE with no pulse and no guard.
  - RX_DATA: sample line_s every CLKS_PER_BIT cycles and shift it in LSB first. After bit 7 go to RX_STOP.
  - RX_STOP: sample line_s one bit period after bit 7.
    - If 1: next cycle rx_data=shifted byte and rx_valid=1 for exactly one cycle.
    - If 0: frame_err=1 for one cycle and rx_data is unchanged.
    - Either way go to GUARD.
  - TX: pad_t=0 for exactly 10*CLKS_PER_BIT cycles. pad_i carries the start bit 0, then data[0..7], then stop bit 1, each held CLKS_PER_BIT cycles. pad_t and pad_i are registered and change together. Then pad_t=1 and go to GUARD. line_s is ignored during TX because it carries our own echo.
  - GUARD: pad_t=1 for GUARD_BITS*CLKS_PER_BIT cycles and line_s is ignored. Then go to IDLE.
- pad_i=1 whenever pad_t=1.
- Counters:
  - Bit counter is wide enough for CLKS_PER_BIT-1, wrapping down to 0.
  - Bit index is 4 bits and never exceeds 9.
  - GUARD counts the bit counter GUARD_BITS times.
- tx_valid held high while busy: no accept, no effect, no loss; accepted on the first IDLE cycle after GUARD.
- tx_data changes after accept do not affect the frame in flight.
- Line held low in IDLE (stuck low): no new start_det, no RX; TX may still start because pad_t drives over the pull-up.

Test Plan (CLKS_PER_BIT=4, GUARD_BITS=2, SYNC_STAGES=2):
- Reset, then idle 20 cycles -> pad_t=1, pad_i=1, busy=0, rx_valid=0, frame_err=0, tx_ready=1 throughout.
- Drive pad_o with a 0xA5 frame (0,1,0,1,0,0,1,0,1,1), 4 cycles per bit -> single rx_valid pulse with rx_data=0xA5. pad_t stays 1. tx_ready=0 until 8 cycles after the stop sample.
- tx_valid=1, tx_data=0x3C for one accepted cycle -> pad_t=0 for exactly 40 cycles. pad_i per bit: 0,0,0,1,1,1,1,0,0,1. Then pad_t=1, busy for 8 more cycles, tx_ready=1 after.
- pad_o low for 1 cycle in IDLE -> back to IDLE after the mid-start sample. No rx_valid, no frame_err, tx_ready=1 again with no guard.
- Frame 0x5A with stop bit 0 -> frame_err pulse once, rx_valid stays 0, rx_data keeps its previous 0xA5.
- start_det and tx_valid in the same cycle -> RX frame received (rx_valid), TX starts after GUARD.
- rst_n low mid-TX -> pad_t=1 with no clock edge required, state IDLE after release.
